// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 clock and decodes frames into bytes and key events.
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_kbd_rx #(
  parameter int FILT_LEN       = 4,
  parameter int TIMEOUT_CYCLES = 60000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_release,
  output logic       key_strobe,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int CW = $clog2(FILT_LEN + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t     state_q, state_d;
  logic       ps2_clk_p0, ps2_clk_p1;
  logic       ps2_data_p0, ps2_data_p1;
  logic       filt_clk;
  logic [CW-1:0] filt_cnt;
  logic       fall;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic       good, perr, ferr;
  logic       flag_ext, flag_rel;
  logic       timeout;

  // Stage p0/p1: two-flop synchronizers, idle-high after reset
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ps2_clk_p0  <= 1'b1;
      ps2_clk_p1  <= 1'b1;
      ps2_data_p0 <= 1'b1;
      ps2_data_p1 <= 1'b1;
    end else begin
      ps2_clk_p0  <= ps2_clk_in;
      ps2_clk_p1  <= ps2_clk_p0;
      ps2_data_p0 <= ps2_data_in;
      ps2_data_p1 <= ps2_data_p0;
    end
  end

  // Glitch filter: level flips only after FILT_LEN consecutive differing samples
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (ps2_clk_p1 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_cnt == CW'(FILT_LEN - 1)) begin
      filt_clk <= ps2_clk_p1;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign fall = filt_clk && !ps2_clk_p1 && (filt_cnt == CW'(FILT_LEN - 1));

`ifdef PS2_RX_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // frame_err lands TIMEOUT_CYCLES cycles after the filtered clock last fell
  always_ff @(posedge clk_sys) begin
    if (reset || fall || state_q == IDLE) wd_cnt <= '0;
    else                                  wd_cnt <= wd_cnt + 1'b1;
  end

  assign timeout = (state_q != IDLE) && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    good      = 1'b0;
    perr      = 1'b0;
    ferr      = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!ps2_data_p1) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {ps2_data_p1, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = ps2_data_p1;
          state_d = STOP;
        end
        default: begin
          state_d = IDLE;
          if (!(^{shift_q, par_q})) perr = 1'b1;
          else if (ps2_data_p1)     good = 1'b1;
          else                      ferr = 1'b1;
        end
      endcase
    end else if (timeout) begin
      state_d = IDLE;
      ferr    = 1'b1;
    end
  end

  // Output stage: results of the stop-bit cycle appear one cycle later
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rx_byte     <= '0;
      rx_valid    <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_strobe  <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      flag_ext    <= 1'b0;
      flag_rel    <= 1'b0;
    end else begin
      rx_valid   <= good;
      parity_err <= perr;
      frame_err  <= ferr;
      key_strobe <= 1'b0;
      if (good) begin
        rx_byte <= shift_q;
        if (shift_q == 8'hF0) begin
          flag_rel <= 1'b1;
        end else if (shift_q == 8'hE0) begin
          flag_ext <= 1'b1;
        end else begin
          key_code    <= shift_q;
          key_ext     <= flag_ext;
          key_release <= flag_rel;
          key_strobe  <= 1'b1;
          flag_ext    <= 1'b0;
          flag_rel    <= 1'b0;
        end
      end
      if (perr || ferr) begin
        flag_ext <= 1'b0;
        flag_rel <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed scenarios plus randomized frames against a byte-level model.
module tb_ps2_kbd_rx;
  localparam int FILT = 4;
  localparam int TMO  = 300;
  localparam int HALF = 12;
  localparam int LAT  = 2 + FILT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_byte, key_code;
  logic       rx_valid, key_ext, key_release, key_strobe, parity_err, frame_err;

  ps2_kbd_rx #(.FILT_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_sys(clk), .reset(rst), .ps2_clk_in(ps2_clk), .ps2_data_in(ps2_data),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .key_code(key_code), .key_ext(key_ext),
    .key_release(key_release), .key_strobe(key_strobe), .parity_err(parity_err),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_rx = 0, n_key = 0, n_par = 0, n_frm = 0;
  int last_pulse_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rx_valid)   n_rx  <= n_rx + 1;
    if (key_strobe) n_key <= n_key + 1;
    if (parity_err) n_par <= n_par + 1;
    if (frame_err)  n_frm <= n_frm + 1;
    if (rx_valid || parity_err || frame_err) last_pulse_cyc <= cyc;
  end

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte-level reference model
  logic [7:0] m_byte, m_code;
  logic       m_ext, m_rel, f_ext, f_rel;
  int e_rx, e_key, e_par, e_frm;
  int b_rx, b_key, b_par, b_frm;
  int last_fall = 0;

  task automatic model_reset();
    m_byte = 8'h00; m_code = 8'h00; m_ext = 1'b0; m_rel = 1'b0; f_ext = 1'b0; f_rel = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bp, input bit bs);
    e_rx = 0; e_key = 0; e_par = 0; e_frm = 0;
    if (bp) begin
      e_par = 1; f_ext = 1'b0; f_rel = 1'b0;
    end else if (bs) begin
      e_frm = 1; f_ext = 1'b0; f_rel = 1'b0;
    end else begin
      e_rx = 1; m_byte = b;
      if (b == 8'hF0) f_rel = 1'b1;
      else if (b == 8'hE0) f_ext = 1'b1;
      else begin
        e_key = 1; m_code = b; m_ext = f_ext; m_rel = f_rel; f_ext = 1'b0; f_rel = 1'b0;
      end
    end
  endtask

  task automatic snap();
    b_rx = n_rx; b_key = n_key; b_par = n_par; b_frm = n_frm;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, " rx_byte"},     32'(rx_byte),     32'(m_byte));
    chk({tag, " key_code"},    32'(key_code),    32'(m_code));
    chk({tag, " key_ext"},     32'(key_ext),     32'(m_ext));
    chk({tag, " key_release"}, 32'(key_release), 32'(m_rel));
  endtask

  task automatic check_counts(input string tag);
    chk({tag, " rx_valid count"},   32'(n_rx - b_rx),   32'(e_rx));
    chk({tag, " key_strobe count"}, 32'(n_key - b_key), 32'(e_key));
    chk({tag, " parity_err count"}, 32'(n_par - b_par), 32'(e_par));
    chk({tag, " frame_err count"},  32'(n_frm - b_frm), 32'(e_frm));
  endtask

  task automatic ps2_bit(input logic d);
    @(negedge clk) ps2_data = d;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] b, input bit bp, input bit bs, input int nbits);
    logic [10:0] fr;
    fr = {~bs, (~^b) ^ bp, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
    @(negedge clk) ps2_data = 1'b1;
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b, input bit bp, input bit bs);
    snap();
    send_bits(b, bp, bs, 11);
    repeat (4) @(negedge clk);
    model_frame(b, bp, bs);
    check_counts(tag);
    check_outputs(tag);
    if (e_rx + e_par + e_frm > 0) chk({tag, " latency"}, 32'(last_pulse_cyc - last_fall), 32'(LAT));
  endtask

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset rx_valid", 32'(rx_valid), 32'd0);
    chk("reset key_strobe", 32'(key_strobe), 32'd0);
    chk("reset parity_err", 32'(parity_err), 32'd0);
    chk("reset frame_err", 32'(frame_err), 32'd0);
    check_outputs("reset");

    run_frame("make 1C", 8'h1C, 1'b0, 1'b0);
    run_frame("F0 prefix", 8'hF0, 1'b0, 1'b0);
    run_frame("break 1C", 8'h1C, 1'b0, 1'b0);
    run_frame("E0 prefix", 8'hE0, 1'b0, 1'b0);
    run_frame("E0 repeat", 8'hE0, 1'b0, 1'b0);
    run_frame("F0 after E0", 8'hF0, 1'b0, 1'b0);
    run_frame("ext break 75", 8'h75, 1'b0, 1'b0);
    run_frame("plain 75", 8'h75, 1'b0, 1'b0);
    run_frame("F0 pending", 8'hF0, 1'b0, 1'b0);
    run_frame("bad parity", 8'h1C, 1'b1, 1'b0);
    run_frame("after parity err", 8'h1C, 1'b0, 1'b0);
    run_frame("bad stop", 8'h1C, 1'b0, 1'b1);
    run_frame("bad parity+stop", 8'h3B, 1'b1, 1'b1);

    // Short clock glitch while data looks like a start bit must not be taken
    snap();
    @(negedge clk) ps2_data = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    chk("glitch pulses", 32'((n_rx - b_rx) + (n_par - b_par) + (n_frm - b_frm)), 32'd0);
    run_frame("after glitch", 8'h33, 1'b0, 1'b0);

    // Truncated frame: four falling edges then silence
    run_frame("F0 before trunc", 8'hF0, 1'b0, 1'b0);
    snap();
    send_bits(8'h5A, 1'b0, 1'b0, 4);
`ifdef PS2_RX_TIMEOUT_EN
    repeat (LAT + TMO + 8) @(negedge clk);
    e_rx = 0; e_key = 0; e_par = 0; e_frm = 1; f_ext = 1'b0; f_rel = 1'b0;
    check_counts("timeout");
    chk("timeout latency", 32'(last_pulse_cyc - last_fall), 32'(LAT + TMO));
`else
    repeat (200) @(negedge clk);
    e_rx = 0; e_key = 0; e_par = 0; e_frm = 0;
    check_counts("truncated wait");
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_reset();
`endif
    check_outputs("after truncation");
    run_frame("clean 2A", 8'h2A, 1'b0, 1'b0);

    // Reset in the middle of a frame, with a release prefix pending
    run_frame("F0 before reset", 8'hF0, 1'b0, 1'b0);
    snap();
    send_bits(8'h77, 1'b0, 1'b0, 5);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("midframe reset pulses", 32'((n_rx - b_rx) + (n_par - b_par) + (n_frm - b_frm)), 32'd0);
    check_outputs("midframe reset");
    run_frame("after reset 16", 8'h16, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] b;
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) b = 8'hF0;
      else if (r == 1) b = 8'hE0;
      else b = 8'($urandom);
      run_frame($sformatf("rand%0d", i), b, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
